memory: RTL and testbench

//  Behavioural SPI-NOR flash slave with a byte-parallel host interface, clocked by SCK.

---
 rtl/memory.sv | 204 ++++++++++++++++++++
 tb/tb_memory.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/memory.sv
// Behavioural SPI-NOR flash slave, byte-parallel host side, clocked by SCK.
// Optional bulk erase (opcode 8'hC7) built when MEM_ERASE_EN is defined.
module memory #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter logic [7:0]  MANUF_ID   = 8'h20,
  parameter logic [7:0]  MEM_TYPE   = 8'h20,
  parameter logic [7:0]  MEM_CAP    = 8'h08
) (
  input  logic       SCK,
  input  logic       RESET,
  input  logic       S,
  input  logic       W_ENABLE,
  input  logic       DATA_DONE,
  input  logic [7:0] D,
  output logic [7:0] Q
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_WRDI = 8'h04;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_RDID = 8'h9F;
  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_PP   = 8'h02;
`ifdef MEM_ERASE_EN
  localparam logic [7:0] OP_BE   = 8'hC7;
`endif

  typedef enum logic [2:0] {
    st_idle,
    st_addr,
    st_rd_data,
    st_pp_data,
    st_rdid_out,
    st_rdsr_out,
    st_erase,
    st_ignore
  } state_e;

  state_e                  state_q, state_d;
  logic [7:0]              q_q, q_d;
  logic                    wel_q, wel_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [1:0]              idx_q, idx_d;
  logic                    is_read_q, is_read_d;

  logic                    mem_we;
  logic [7:0]              mem_wdata;
`ifdef MEM_ERASE_EN
  logic                    erase_all;
`endif

  // Behavioural array: erased (all ones) at power-up, never touched by RESET.
  logic [7:0] mem [DEPTH] = '{default: 8'hFF};

  logic                  accept;
  logic                  wr_permit;
  logic [7:0]            status;
  logic [ADDR_WIDTH-1:0] d_addr;

  assign accept    = ~S & DATA_DONE;
  assign wr_permit = wel_q & W_ENABLE;
  assign status    = {6'b0, wel_q, 1'b0};
  assign d_addr    = D[ADDR_WIDTH-1:0];
  assign Q         = q_q;

  function automatic logic [7:0] id_byte(input logic [1:0] i);
    case (i)
      2'd0:    id_byte = MANUF_ID;
      2'd1:    id_byte = MEM_TYPE;
      default: id_byte = MEM_CAP;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    q_d       = q_q;
    wel_d     = wel_q;
    addr_d    = addr_q;
    idx_d     = idx_q;
    is_read_d = is_read_q;
    mem_we    = 1'b0;
    mem_wdata = mem[addr_q] & D;
`ifdef MEM_ERASE_EN
    erase_all = 1'b0;
`endif

    if (S) begin
      // Deselect ends any command; a finished program/erase drops the latch.
      state_d = st_idle;
      q_d     = 8'h00;
      if (state_q == st_pp_data || state_q == st_erase) begin
        wel_d = 1'b0;
      end
    end else if (accept) begin
      unique case (state_q)
        st_idle: begin
          case (D)
            OP_WREN: begin
              wel_d   = 1'b1;
              state_d = st_ignore;
            end
            OP_WRDI: begin
              wel_d   = 1'b0;
              state_d = st_ignore;
            end
            OP_RDSR: begin
              q_d     = status;
              state_d = st_rdsr_out;
            end
            OP_RDID: begin
              q_d     = MANUF_ID;
              idx_d   = 2'd1;
              state_d = st_rdid_out;
            end
            OP_READ: begin
              is_read_d = 1'b1;
              state_d   = st_addr;
            end
            OP_PP: begin
              is_read_d = 1'b0;
              state_d   = st_addr;
            end
`ifdef MEM_ERASE_EN
            OP_BE: begin
              if (wr_permit) begin
                erase_all = 1'b1;
                state_d   = st_erase;
              end else begin
                state_d   = st_ignore;
              end
            end
`endif
            default: state_d = st_ignore;
          endcase
        end
        st_addr: begin
          if (is_read_q) begin
            q_d     = mem[d_addr];
            addr_d  = d_addr + ADDR_ONE;
            state_d = st_rd_data;
          end else begin
            addr_d  = d_addr;
            state_d = st_pp_data;
          end
        end
        st_rd_data: begin
          q_d    = mem[addr_q];
          addr_d = addr_q + ADDR_ONE;
        end
        st_pp_data: begin
          // NOR programming can only clear bits; a blocked byte is dropped.
          mem_we = wr_permit;
          addr_d = addr_q + ADDR_ONE;
        end
        st_rdid_out: begin
          q_d   = id_byte(idx_q);
          idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end
        st_rdsr_out: q_d = status;
        st_erase:    ;
        st_ignore:   ;
        default:     state_d = st_idle;
      endcase
    end
  end

  always_ff @(posedge SCK or posedge RESET) begin
    if (RESET) begin
      state_q   <= st_idle;
      q_q       <= 8'h00;
      wel_q     <= 1'b0;
      addr_q    <= '0;
      idx_q     <= 2'd0;
      is_read_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      wel_q     <= wel_d;
      addr_q    <= addr_d;
      idx_q     <= idx_d;
      is_read_q <= is_read_d;
    end
  end

  always_ff @(posedge SCK) begin
`ifdef MEM_ERASE_EN
    if (erase_all) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'hFF;
      end
    end else if (mem_we) begin
      mem[addr_q] <= mem_wdata;
    end
`else
    if (mem_we) begin
      mem[addr_q] <= mem_wdata;
    end
`endif
  end

endmodule

// File: tb/tb_memory.sv
// Directed self-checking bench for the SPI-NOR flash slave model.
// Follows MEM_ERASE_EN so the same sequence covers both builds.
module tb_memory;

  logic       SCK = 1'b0;
  logic       RESET;
  logic       S;
  logic       W_ENABLE;
  logic       DATA_DONE;
  logic [7:0] D;
  logic [7:0] Q;

  int errors = 0;
  int checks = 0;

  memory dut (
    .SCK       (SCK),
    .RESET     (RESET),
    .S         (S),
    .W_ENABLE  (W_ENABLE),
    .DATA_DONE (DATA_DONE),
    .D         (D),
    .Q         (Q)
  );

  always #5 SCK = ~SCK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] exp);
    checks++;
    assert (Q === exp) else begin
      errors++;
      $error("FAIL %s: Q=%h expected %h", tag, Q, exp);
    end
  endtask

  // One accepted byte: drive on the falling edge, settle 1ns after the rising edge.
  task automatic strobe(input logic [7:0] b);
    @(negedge SCK);
    S         = 1'b0;
    D         = b;
    DATA_DONE = 1'b1;
    @(posedge SCK);
    #1;
    DATA_DONE = 1'b0;
  endtask

  task automatic deselect();
    @(negedge SCK);
    S         = 1'b1;
    DATA_DONE = 1'b0;
    @(posedge SCK);
    #1;
  endtask

  task automatic idle_cycle();
    @(negedge SCK);
    @(posedge SCK);
    #1;
  endtask

  initial begin
    RESET     = 1'b1;
    S         = 1'b1;
    W_ENABLE  = 1'b1;
    DATA_DONE = 1'b0;
    D         = 8'h00;
    repeat (2) @(posedge SCK);
    #1;
    check("reset_q", 8'h00);
    @(negedge SCK);
    RESET = 1'b0;
    idle_cycle();
    check("after_reset_q", 8'h00);

    // Status after reset: WEL clear
    strobe(8'h05); check("rdsr_reset", 8'h00);
    deselect();

    // JEDEC ID with wrap
    strobe(8'h9F); check("rdid_0", 8'h20);
    strobe(8'h11); check("rdid_1", 8'h20);
    strobe(8'h22); check("rdid_2", 8'h08);
    strobe(8'h33); check("rdid_wrap", 8'h20);
    deselect();    check("deselect_q", 8'h00);

    // Write enable latch visible in status; held with no strobe
    strobe(8'h06); deselect();
    strobe(8'h05); check("rdsr_wel", 8'h02);
    idle_cycle();  check("no_strobe_hold", 8'h02);
    strobe(8'h00); check("rdsr_reload", 8'h02);
    deselect();

    // Page program across the address wrap FF -> 00
    strobe(8'h02); strobe(8'hFE);
    strobe(8'hAA); strobe(8'h55); strobe(8'h0F);
    deselect();
    strobe(8'h05); check("wel_cleared_pp", 8'h00);
    deselect();

    strobe(8'h03); strobe(8'hFE); check("read_fe", 8'hAA);
    strobe(8'h00); check("read_ff", 8'h55);
    strobe(8'h00); check("read_wrap_00", 8'h0F);
    deselect();

    // W_ENABLE low blocks programming
    W_ENABLE = 1'b0;
    strobe(8'h06); deselect();
    strobe(8'h02); strobe(8'h10); strobe(8'h00);
    deselect();
    W_ENABLE = 1'b1;
    strobe(8'h03); strobe(8'h10); check("wen_blocked", 8'hFF);
    deselect();

    // Program without WREN is dropped
    strobe(8'h02); strobe(8'h20); strobe(8'h00);
    deselect();
    strobe(8'h03); strobe(8'h20); check("pp_no_wren", 8'hFF);
    deselect();

    // W_ENABLE dropped mid-program blocks only the later bytes
    strobe(8'h06); deselect();
    strobe(8'h02); strobe(8'h30); strobe(8'h00);
    W_ENABLE = 1'b0;
    strobe(8'h00);
    deselect();
    W_ENABLE = 1'b1;
    strobe(8'h03); strobe(8'h30); check("mid_pp_first", 8'h00);
    strobe(8'h00); check("mid_pp_second", 8'hFF);
    deselect();

    // Programming only clears bits: F0 then 3C leaves 30
    strobe(8'h06); deselect();
    strobe(8'h02); strobe(8'h50); strobe(8'hF0); deselect();
    strobe(8'h06); deselect();
    strobe(8'h02); strobe(8'h50); strobe(8'h3C); deselect();
    strobe(8'h03); strobe(8'h50); check("pp_and", 8'h30);
    deselect();

    // Unknown opcode ignores the rest of the command, WEL survives
    strobe(8'h06); deselect();
    strobe(8'hAB); check("unknown_q", 8'h00);
    strobe(8'h05); check("ignore_strobe", 8'h00);
    deselect();
    strobe(8'h05); check("wel_kept", 8'h02);
    deselect();
    strobe(8'h04); deselect();
    strobe(8'h05); check("wrdi", 8'h00);
    deselect();

    // Bulk erase
    strobe(8'h06); deselect();
    strobe(8'hC7);
    strobe(8'h05); check("c7_no_status", 8'h00);
    deselect();
`ifdef MEM_ERASE_EN
    strobe(8'h03); strobe(8'hFE); check("erase_fe", 8'hFF);
    strobe(8'h00); check("erase_ff", 8'hFF);
    deselect();
    strobe(8'h05); check("erase_wel", 8'h00);
    deselect();
`else
    strobe(8'h03); strobe(8'hFE); check("c7_untouched", 8'hAA);
    deselect();
    strobe(8'h05); check("c7_wel_kept", 8'h02);
    deselect();
`endif

    // Asynchronous reset in the middle of a read
    strobe(8'h06); deselect();
    strobe(8'h03); strobe(8'h40); check("read_40", 8'hFF);
    @(negedge SCK);
    #2;
    RESET = 1'b1;
    #1;
    check("async_reset_q", 8'h00);
    @(negedge SCK);
    RESET = 1'b0;
    // If reset did not return to idle, this would read mem[41] = FF
    strobe(8'h05); check("reset_idle_wel", 8'h00);
    deselect();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
